// File: rtl/mux8to1_pkg.sv
// ---------------------------------------------------------------------------
// mux8to1_pkg
// Shared constants and types for the eight-way data selector.
//   NUM_LANES : number of input lanes (8)
//   SEL_W     : select width (3)
//   sel_t     : lane select type
//   onehot_t  : one-hot lane mask type
// Optional build macro used by the top level: MUX8TO1_REG_OUT_EN
// ---------------------------------------------------------------------------
package mux8to1_pkg;
  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;

  typedef logic [SEL_W-1:0]     sel_t;
  typedef logic [NUM_LANES-1:0] onehot_t;
endpackage

// File: rtl/mux8to1_intf.sv
// ---------------------------------------------------------------------------
// intf
// Signal bundle used to drive the selector: data lanes, select and the
// selected output, with clk/rst carried alongside.
//   clk, rst : clock and asynchronous active-high reset (interface ports)
//   in       : 8*WIDTH packed lanes, lane 0 in the LSBs
//   sel      : lane select
//   out      : selected lane data
// ---------------------------------------------------------------------------
interface intf
  import mux8to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic clk,
  input logic rst
);
  logic [NUM_LANES*WIDTH-1:0] in;
  sel_t                       sel;
  logic [WIDTH-1:0]           out;
endinterface

// File: rtl/mux8to1_decoder.sv
// ---------------------------------------------------------------------------
// mux8to1_decoder
// Combinational 3-to-8 one-hot decoder.
//   sel    : input  sel_t    lane select
//   onehot : output onehot_t bit k high when sel == k; all zero when sel
//                            carries X/Z (no case item matches)
// ---------------------------------------------------------------------------
module mux8to1_decoder
  import mux8to1_pkg::*;
(
  input  sel_t    sel,
  output onehot_t onehot
);

  // An explicit case (rather than a shift) means an unknown select falls
  // through to the all-zero default in simulation.
  always_comb begin
    onehot = '0;
    case (sel)
      3'd0:    onehot = 8'b0000_0001;
      3'd1:    onehot = 8'b0000_0010;
      3'd2:    onehot = 8'b0000_0100;
      3'd3:    onehot = 8'b0000_1000;
      3'd4:    onehot = 8'b0001_0000;
      3'd5:    onehot = 8'b0010_0000;
      3'd6:    onehot = 8'b0100_0000;
      3'd7:    onehot = 8'b1000_0000;
      default: onehot = '0;
    endcase
  end

endmodule

// File: rtl/mux_8to1.sv
// ---------------------------------------------------------------------------
// mux_8to1
// Eight-way data selector with one-hot select report.
//   WIDTH      : bits per lane
//   clk        : input  clock, rising edge
//   rst        : input  asynchronous active-high reset
//   in         : input  8*WIDTH packed lanes, lane k at in[k*WIDTH +: WIDTH]
//   sel        : input  lane select 0..7
//   out        : output selected lane data
//   sel_onehot : output one-hot copy of sel
//   out_valid  : output high from the first clk edge after reset release
// Build option MUX8TO1_REG_OUT_EN: when defined, out and sel_onehot are
// registered (1-cycle latency, reset to 0); otherwise they are combinational.
// ---------------------------------------------------------------------------
module mux_8to1
  import mux8to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES*WIDTH-1:0] in,
  input  sel_t                       sel,
  output logic [WIDTH-1:0]           out,
  output onehot_t                    sel_onehot,
  output logic                       out_valid
);

  onehot_t          mask;
  logic [WIDTH-1:0] lane_masked [NUM_LANES];
  logic [WIDTH-1:0] out_next;

  mux8to1_decoder u_decoder (
    .sel    (sel),
    .onehot (mask)
  );

  // AND-OR select: every lane is gated by its mask bit, so an all-zero mask
  // (unknown select) yields a zero output without extra logic.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_masked[gi] = in[gi*WIDTH +: WIDTH] & {WIDTH{mask[gi]}};
    end
  endgenerate

  always_comb begin
    out_next = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      out_next = out_next | lane_masked[k];
    end
  end

`ifdef MUX8TO1_REG_OUT_EN
  logic [WIDTH-1:0] out_reg;
  onehot_t          onehot_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg    <= '0;
      onehot_reg <= '0;
    end else begin
      out_reg    <= out_next;
      onehot_reg <= mask;
    end
  end

  assign out        = out_reg;
  assign sel_onehot = onehot_reg;
`else
  assign out        = out_next;
  assign sel_onehot = mask;
`endif

  // Valid is the only state shared by both builds: low in reset, high from
  // the first edge after release onward.
  logic valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b1;
    end
  end

  assign out_valid = valid_reg;

endmodule

// File: tb/tb_mux_8to1.sv
// ---------------------------------------------------------------------------
// tb_mux_8to1
// Directed bench for mux_8to1: a WIDTH=1 instance driven through intf and a
// WIDTH=8 instance for the wide-lane vectors. Handles both the combinational
// and the registered (MUX8TO1_REG_OUT_EN) build.
// ---------------------------------------------------------------------------
module tb_mux_8to1;
  import mux8to1_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MUX8TO1_REG_OUT_EN
  localparam bit REG_MODE = 1'b1;
`else
  localparam bit REG_MODE = 1'b0;
`endif

  // WIDTH=1 instance, driven through the interface bundle
  intf #(.WIDTH(1)) bus (.clk(clk), .rst(rst));
  onehot_t oh1;
  logic    v1;

  mux_8to1 #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .in         (bus.in),
    .sel        (bus.sel),
    .out        (bus.out),
    .sel_onehot (oh1),
    .out_valid  (v1)
  );

  // WIDTH=8 instance
  logic [63:0] in8;
  sel_t        sel8;
  logic [7:0]  out8;
  onehot_t     oh8;
  logic        v8;

  mux_8to1 #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .in         (in8),
    .sel        (sel8),
    .out        (out8),
    .sel_onehot (oh8),
    .out_valid  (v8)
  );

  // Expected values of the WIDTH=1 instance for the previous step; in the
  // registered build the outputs must still show these before the edge.
  logic    prev_out = 1'b0;
  onehot_t prev_oh  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one WIDTH=1 vector after a falling edge, check before and after
  // the next rising edge.
  task automatic apply(input string tag, input logic [7:0] in_v, input logic [2:0] sel_v);
    logic    e_out;
    onehot_t e_oh;
    @(negedge clk);
    bus.in  = in_v;
    bus.sel = sel_v;
    #1;
    if ($isunknown(bus.sel)) begin
      e_out = 1'b0;
      e_oh  = '0;
    end else begin
      e_out = in_v[bus.sel];
      e_oh  = onehot_t'(8'd1 << bus.sel);
    end
    if (REG_MODE) begin
      chk({tag, "_pre_out"}, 64'(bus.out), 64'(prev_out));
      chk({tag, "_pre_oh"},  64'(oh1),     64'(prev_oh));
    end else begin
      chk({tag, "_pre_out"}, 64'(bus.out), 64'(e_out));
      chk({tag, "_pre_oh"},  64'(oh1),     64'(e_oh));
    end
    @(posedge clk);
    #1;
    chk({tag, "_out"},   64'(bus.out), 64'(e_out));
    chk({tag, "_oh"},    64'(oh1),     64'(e_oh));
    chk({tag, "_valid"}, 64'(v1),      64'd1);
    $display("step %s: in=%b sel=%b out=%b onehot=%b", tag, in_v, bus.sel, bus.out, oh1);
    prev_out = e_out;
    prev_oh  = e_oh;
  endtask

  initial begin
    logic [2:0] xsel;
    bus.in  = 8'hFF;
    bus.sel = 3'd5;
    in8     = 64'h0;
    sel8    = 3'd0;

    // Reset behaviour with in=FF, sel=5
    #2;
    chk("rst_valid", 64'(v1), 64'd0);
    if (REG_MODE) begin
      chk("rst_out", 64'(bus.out), 64'd0);
      chk("rst_oh",  64'(oh1),     64'd0);
    end else begin
      chk("rst_out", 64'(bus.out), 64'd1);
      chk("rst_oh",  64'(oh1),     64'h20);
    end
    @(posedge clk);
    #1;
    chk("rst_valid_held", 64'(v1), 64'd0);
    if (REG_MODE) chk("rst_out_held", 64'(bus.out), 64'd0);
    $display("step reset: valid=%b out=%b onehot=%b", v1, bus.out, oh1);

    // Re-assert asynchronously mid-cycle after a valid period
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release_valid", 64'(v1), 64'd1);
    chk("release_out",   64'(bus.out), 64'd1);
    chk("release_oh",    64'(oh1),     64'h20);
    $display("step release: valid=%b out=%b onehot=%b", v1, bus.out, oh1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(v1), 64'd0);
    if (REG_MODE) chk("async_oh", 64'(oh1), 64'd0);
    $display("step async_reset: valid=%b onehot=%b", v1, oh1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    prev_out = 1'b1;
    prev_oh  = 8'h20;

    // Exhaustive select on 1010_0110: out = 0,1,1,0,0,1,0,1
    for (int s = 0; s < 8; s++) begin
      apply($sformatf("sweep%0d", s), 8'b1010_0110, 3'(s));
    end

    // Walking one
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 8; s++) begin
        apply($sformatf("walk%0d_%0d", k, s), 8'(8'd1 << k), 3'(s));
      end
    end

    // Simultaneous in/sel change: both steps expect out=1
    apply("simul_a", 8'h0F, 3'd1);
    apply("simul_b", 8'hF0, 3'd6);
    chk("simul_oh", 64'(oh1), 64'h40);

    // Unknown select
    xsel = 3'bx1x;
    apply("xsel", 8'hFF, xsel);

    // Wide lanes
    @(negedge clk);
    in8  = 64'h7766554433221100;
    sel8 = 3'd3;
    @(posedge clk);
    #1;
    chk("wide_sel3_out", 64'(out8), 64'h33);
    chk("wide_sel3_oh",  64'(oh8),  64'h08);
    $display("step wide_sel3: out=%h onehot=%b", out8, oh8);
    @(negedge clk);
    sel8 = 3'd7;
    @(posedge clk);
    #1;
    chk("wide_sel7_out", 64'(out8), 64'h77);
    chk("wide_sel7_oh",  64'(oh8),  64'h80);
    chk("wide_valid",    64'(v8),   64'd1);
    $display("step wide_sel7: out=%h onehot=%b", out8, oh8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
